// File: rtl/seq_shift_if.sv
// Start/done handshake bundle between execute-stage control and the
// sequential shift controller.
interface seq_shift_if #(
  parameter int n   = 32,
  parameter int SHW = 5
);
  logic           start;
  logic           abort;
  logic [1:0]     op;
  logic [n-1:0]   operand;
  logic [SHW-1:0] shamt;
  logic           busy;
  logic           done;
  logic [n-1:0]   result;

  modport master (
    output start, abort, op, operand, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, abort, op, operand, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/seq_shift_ctrl.sv
// Multi-cycle SLL/SRL/SRA/ROL: one working register shifted one bit per
// clock, sequenced by an IDLE/SHIFT/DONE FSM with a start/done handshake.
module seq_shift_ctrl #(
  parameter int n   = 32,
  parameter int SHW = 5
) (
  input  logic     clk,
  input  logic     rst,
  seq_shift_if.slave sif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  state_t         state, state_nxt;
  logic [n-1:0]   r, r_step;
  logic [SHW-1:0] count;
  logic [1:0]     op_q;
  logic           accept;

  // A new request can only land when no shift is running; it beats abort.
  assign accept = sif.start && (state != SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept)             state_nxt = (sif.shamt == '0) ? DONE : SHIFT;
        else if (state == DONE) state_nxt = IDLE;
      end
      SHIFT: begin
        if (sif.abort)            state_nxt = IDLE;
        else if (count == SHW'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sif.busy = (state == SHIFT);
    sif.done = (state == DONE);
  end

  always_comb begin
    r_step = r;
    unique case (op_q)
      OP_SLL: r_step = {r[n-2:0], 1'b0};
      OP_SRL: r_step = {1'b0, r[n-1:1]};
      OP_SRA: r_step = {r[n-1], r[n-1:1]};
      OP_ROL: r_step = {r[n-2:0], r[n-1]};
      default: r_step = r;
    endcase
  end

  // On abort the partial value is left in place; the caller discards it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r     <= '0;
      count <= '0;
      op_q  <= OP_SLL;
    end else if (accept) begin
      r     <= sif.operand;
      count <= sif.shamt;
      op_q  <= sif.op;
    end else if (state == SHIFT && !sif.abort) begin
      r     <= r_step;
      count <= count - SHW'(1);
    end
  end

  assign sif.result = r;

endmodule

// File: tb/tb_seq_shift_ctrl.sv
// Directed bench for seq_shift_ctrl: reset, each op, max amount, zero amount,
// back-to-back, abort and ignored start.
module tb_seq_shift_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   edges, busy_cyc;
  logic seen;

  seq_shift_if #(.n(32), .SHW(5)) sif ();

  seq_shift_ctrl #(.n(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are scrambled right after the accepting edge to show they are not re-read.
  task automatic start_op(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
    sif.start = 1'b1; sif.op = o; sif.operand = v; sif.shamt = s;
    tick();
    sif.start = 1'b0; sif.op = ~o; sif.operand = ~v; sif.shamt = ~s;
  endtask

  task automatic run_to_done(input int limit, output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = 0;
    while (sif.done !== 1'b1 && n_edges < limit) begin
      if (sif.busy === 1'b1) n_busy++;
      tick();
      n_edges++;
    end
  endtask

  task automatic watch_no_done(input int cycles, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (sif.done !== 1'b0) hit = 1'b1;
    end
  endtask

  initial begin
    sif.start = 1'b0; sif.abort = 1'b0; sif.op = 2'b00;
    sif.operand = '0; sif.shamt = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy",   32'(sif.busy), 32'd0);
    chk("rst_done",   32'(sif.done), 32'd0);
    chk("rst_result", sif.result,    32'h0);
    rst = 1'b1;
    tick();

    // Reset mid-SHIFT: five steps of 1<<20, then async reset between edges
    start_op(2'b00, 32'h0000_0001, 5'd20);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_busy",   32'(sif.busy), 32'd1);
    chk("mid_result", sif.result,    32'h0000_0020);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy",   32'(sif.busy), 32'd0);
    chk("arst_done",   32'(sif.done), 32'd0);
    chk("arst_result", sif.result,    32'h0);
    tick();
    #2 rst = 1'b1;
    watch_no_done(25, seen);
    chk("arst_no_done", 32'(seen), 32'd0);
    chk("arst_idle",    32'(sif.busy), 32'd0);

    // SLL basic
    start_op(2'b00, 32'h0000_0003, 5'd4);
    run_to_done(64, edges, busy_cyc);
    chk("sll_done",   32'(sif.done), 32'd1);
    chk("sll_edges",  32'(edges),    32'd4);
    chk("sll_busy",   32'(busy_cyc), 32'd4);
    chk("sll_result", sif.result,    32'h0000_0030);
    tick();
    chk("sll_pulse",  32'(sif.done), 32'd0);
    chk("sll_hold",   sif.result,    32'h0000_0030);

    // SRA sign fill, then SRL zero fill
    start_op(2'b10, 32'h8000_00F0, 5'd4);
    run_to_done(64, edges, busy_cyc);
    chk("sra_edges",  32'(edges), 32'd4);
    chk("sra_result", sif.result, 32'hF800_000F);
    tick();
    start_op(2'b01, 32'h8000_00F0, 5'd4);
    run_to_done(64, edges, busy_cyc);
    chk("srl_edges",  32'(edges), 32'd4);
    chk("srl_result", sif.result, 32'h0800_000F);
    tick();

    // ROL by the maximum amount
    start_op(2'b11, 32'h8000_0001, 5'd31);
    run_to_done(64, edges, busy_cyc);
    chk("rol_edges",  32'(edges), 32'd31);
    chk("rol_result", sif.result, 32'hC000_0000);
    tick();

    // Zero amount lands in DONE on the accepting edge; back-to-back start there
    start_op(2'b00, 32'h1234_5678, 5'd0);
    chk("zero_done",   32'(sif.done), 32'd1);
    chk("zero_result", sif.result,    32'h1234_5678);
    start_op(2'b00, 32'h1234_5678, 5'd1);
    chk("b2b_gap",  32'(sif.done), 32'd0);
    chk("b2b_busy", 32'(sif.busy), 32'd1);
    tick();
    chk("b2b_done",   32'(sif.done), 32'd1);
    chk("b2b_result", sif.result,    32'h2468_ACF0);
    tick();
    chk("b2b_end", 32'(sif.done), 32'd0);

    // Abort with an ignored start in between
    start_op(2'b00, 32'h0000_0001, 5'd10);
    tick(); tick();
    start_op(2'b01, 32'hFFFF_FFFF, 5'd2);
    chk("ign_busy",   32'(sif.busy), 32'd1);
    chk("ign_result", sif.result,    32'h0000_0008);
    tick(); tick();
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    chk("abort_busy",    32'(sif.busy), 32'd0);
    chk("abort_done",    32'(sif.done), 32'd0);
    chk("abort_partial", sif.result,    32'h0000_0020);
    watch_no_done(15, seen);
    chk("abort_no_done", 32'(seen), 32'd0);

    // Start and abort together while IDLE: start wins
    sif.abort = 1'b1;
    start_op(2'b01, 32'h0000_0005, 5'd1);
    sif.abort = 1'b0;
    chk("sa_busy", 32'(sif.busy), 32'd1);
    tick();
    chk("sa_done",   32'(sif.done), 32'd1);
    chk("sa_result", sif.result,    32'h0000_0002);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
